// File: rtl/timer_array_ts.sv
// Multi-channel compare timer on the LEGv8 shared tristate bus.
// One prescaler feeds CHANNELS counters; irq summarises the enabled match flags.
module timer_array_ts #(
    parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
    parameter int          CHANNELS      = 4,
    parameter int          WIDTH         = 32,
    parameter int          PRESCALE_BITS = 16
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire  [63:0] data,
    input  logic [31:0] address,
    input  logic        MW,
    input  logic        EN,
    input  logic [1:0]  size,
    output logic        irq
);
    localparam logic [32:0] REGION_END = {1'b0, BASE_ADDR} + 33'(32 * (CHANNELS + 1));
    localparam logic [15:0] ID_VALUE   = {8'(CHANNELS), 8'(WIDTH)};

    logic        hit;
    logic        write_en;
    logic        tick;
    logic [31:0] offset;
    logic [3:0]  slot;
    logic [1:0]  reg_sel;
    logic [63:0] byte_mask;
    logic [63:0] rdata;
    logic [2:0]  ctrl_wr;
    logic        unused_offset;

    logic [PRESCALE_BITS-1:0] prescale_q, prescale_d;
    logic [PRESCALE_BITS-1:0] div_q, div_d;
    logic [CHANNELS-1:0]      run_q, run_d;
    logic [CHANNELS-1:0]      periodic_q, periodic_d;
    logic [CHANNELS-1:0]      ie_q, ie_d;
    logic [CHANNELS-1:0]      flag_q, flag_d;
    logic [WIDTH-1:0]         count_q [CHANNELS];
    logic [WIDTH-1:0]         count_d [CHANNELS];
    logic [WIDTH-1:0]         compare_q [CHANNELS];
    logic [WIDTH-1:0]         compare_d [CHANNELS];

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                                input logic [63:0] new_v,
                                                input logic [63:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign hit           = ({1'b0, address} >= {1'b0, BASE_ADDR}) && ({1'b0, address} < REGION_END);
    assign offset        = address - BASE_ADDR;
    assign slot          = offset[8:5];
    assign reg_sel       = offset[4:3];
    assign unused_offset = ^{offset[31:9], offset[2:0]};
    assign write_en      = MW && hit;
    assign tick          = (div_q == prescale_q);
    assign irq           = |(flag_q & ie_q);

    always_comb begin
        case (size)
            2'b00:   byte_mask = 64'h0000_0000_0000_00FF;
            2'b01:   byte_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   byte_mask = 64'h0000_0000_FFFF_FFFF;
            default: byte_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    // Slot 0 holds the global registers; slot i+1 holds channel i.
    always_comb begin
        rdata = '0;
        if (slot == 4'd0) begin
            case (reg_sel)
                2'd0:    rdata = 64'(prescale_q);
                2'd1:    rdata = 64'(flag_q);
                2'd2:    rdata = 64'(ID_VALUE);
                default: rdata = '0;
            endcase
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(slot) == i + 1) begin
                case (reg_sel)
                    2'd0:    rdata = 64'({ie_q[i], periodic_q[i], run_q[i]});
                    2'd1:    rdata = 64'(count_q[i]);
                    2'd2:    rdata = 64'(compare_q[i]);
                    default: rdata = 64'(flag_q[i]);
                endcase
            end
        end
    end

    assign data = (EN && hit) ? (rdata & byte_mask) : 'z;

    // Bus writes to CTRL/COUNT swallow that channel's tick; flag set is applied after clear.
    always_comb begin
        prescale_d = prescale_q;
        div_d      = tick ? '0 : div_q + PRESCALE_BITS'(1);
        run_d      = run_q;
        periodic_d = periodic_q;
        ie_d       = ie_q;
        flag_d     = flag_q;
        ctrl_wr    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            count_d[i]   = count_q[i];
            compare_d[i] = compare_q[i];
        end
        if (write_en && slot == 4'd0 && reg_sel == 2'd0) begin
            prescale_d = PRESCALE_BITS'(merge_bytes(64'(prescale_q), data, byte_mask));
            div_d      = '0;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (write_en && int'(slot) == i + 1) begin
                case (reg_sel)
                    2'd0: begin
                        ctrl_wr = 3'(merge_bytes(64'({ie_q[i], periodic_q[i], run_q[i]}), data, byte_mask));
                        run_d[i]      = ctrl_wr[0];
                        periodic_d[i] = ctrl_wr[1];
                        ie_d[i]       = ctrl_wr[2];
                    end
                    2'd1:    count_d[i]   = WIDTH'(merge_bytes(64'(count_q[i]), data, byte_mask));
                    2'd2:    compare_d[i] = WIDTH'(merge_bytes(64'(compare_q[i]), data, byte_mask));
                    default: if (data[0]) flag_d[i] = 1'b0;
                endcase
            end
            if (tick && run_q[i] && !(write_en && int'(slot) == i + 1 && !reg_sel[1])) begin
                if (count_q[i] == compare_q[i]) begin
                    flag_d[i]  = 1'b1;
                    count_d[i] = '0;
                    if (!periodic_q[i]) run_d[i] = 1'b0;
                end else begin
                    count_d[i] = count_q[i] + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescale_q <= '0;
            div_q      <= '0;
            run_q      <= '0;
            periodic_q <= '0;
            ie_q       <= '0;
            flag_q     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i]   <= '0;
                compare_q[i] <= '0;
            end
        end else begin
            prescale_q <= prescale_d;
            div_q      <= div_d;
            run_q      <= run_d;
            periodic_q <= periodic_d;
            ie_q       <= ie_d;
            flag_q     <= flag_d;
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i]   <= count_d[i];
                compare_q[i] <= compare_d[i];
            end
        end
    end
endmodule

// File: doc/timer_array_ts.md
# timer_array_ts

Parametrised multi-channel, memory-mapped timer peripheral on the LEGv8 shared tristate data/address bus. It is the next-generation replacement for the single timer at 0x80000000. It provides CHANNELS independent compare timers of WIDTH bits each, driven by a shared prescaler. Each channel runs one-shot or periodic and has a sticky match flag. A single interrupt line summarises all channels.

## Interface
Parameters:
- BASE_ADDR, 32'h80000000: region base; 8-byte aligned register slots.
- CHANNELS, 4: number of timer channels, legal range 1..8.
- WIDTH, 32: counter/compare width, legal range 8..64.
- PRESCALE_BITS, 16: width of the prescaler divider.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- data  inout  64  shared data bus; high-Z unless a read hits the region.
- address  input  32  bus address.
- MW  input  1  memory write strobe.
- EN  input  1  memory read enable; the bus DS=11 decode.
- size  input  2  access size: 00 byte, 01 half, 10 word, 11 double.
- irq  output  1  OR over channels of (FLAG & IE).

## Operation
- Hit: BASE_ADDR ≤ address < BASE_ADDR + 0x20*(CHANNELS+1). Offset = address − BASE_ADDR.
- Global slot, offset 0x00–0x1F:
  - 0x00 PRESCALE, R/W, PRESCALE_BITS wide.
  - 0x08 IRQ_STATUS, RO; bit i = FLAG of channel i.
  - 0x10 ID, RO: {CHANNELS[7:0], WIDTH[7:0]} in the low 16 bits.
- Channel i slot, at 0x20*(i+1):
  - +0x00 CTRL: bit0 RUN, bit1 PERIODIC, bit2 IE.
  - +0x08 COUNT, R/W.
  - +0x10 COMPARE, R/W.
  - +0x18 STATUS: bit0 FLAG; write 1 to clear.
- Unmapped offsets inside the region read 0; writes to them are ignored. Register bits above a register's width read 0.
- Access size:
  - Writes update only the low 2^size bytes of the target register; upper bytes are retained.
  - Reads drive the register value masked to the low 2^size bytes, upper bytes 0.
  - Register offsets must be 8-byte aligned; address[2:0] is ignored.
- Prescaler:
  - The divider counter increments each clock.
  - When divider == PRESCALE: a one-cycle tick is asserted and the divider is cleared.
  - PRESCALE=0 gives a tick every clock.
  - Writing PRESCALE clears the divider.
- Channel behaviour, on a tick with RUN=1:
  - If COUNT == COMPARE: set FLAG, COUNT←0; if PERIODIC=0, RUN←0.
  - Otherwise COUNT←COUNT+1, modulo 2^WIDTH.
  - Period is (COMPARE+1)*(PRESCALE+1) clocks.
  - RUN=0 freezes COUNT.
- Simultaneous events:
  - A bus write to COUNT or CTRL in the same cycle as a tick: the bus write wins, and the tick is lost for that channel.
  - A FLAG clear in the same cycle as a FLAG set: the set wins.
  - A bus write to COMPARE takes effect for the next tick's comparison.
- Reset, from any state including mid-count:
  - All registers, the divider, and all FLAGs go to 0.
  - irq=0 and data is high-Z.
  - Takes effect immediately (asynchronous).

## Timing
- Reads are combinational: data is valid while EN=1 and the address hits, so the bus master can sample on the falling edge. Bus contention outside the region is never caused.
- Writes are captured at the rising clock edge while MW=1 and the address hits.
- FLAG and the COUNT wrap are visible in the cycle after the tick edge.
- irq is combinational from the registered FLAG/IE: it asserts the same cycle FLAG becomes 1 and deasserts the cycle after the clearing write.
- Read-during-write returns the old value.
- Latency from setting RUN to the first increment is at most PRESCALE+1 clocks.

## Test plan
- Reset: deassert reset with EN=0 → data=Z and irq=0. Reads of CTRL0, COUNT0 and PRESCALE → 0. ID read → 0x0420 for CHANNELS=4, WIDTH=32.
- Periodic with prescaler: PRESCALE=3, COMPARE0=4, CTRL0=0b111 → FLAG0 set every 20 clocks, irq high. Write 1 to STATUS0 → irq low the next cycle. Next FLAG0 set comes 20 clocks after the previous one.
- One-shot: PRESCALE=0, COMPARE1=2, CTRL1=0b001 → FLAG1 set 3 ticks after RUN. RUN1 reads 0 afterwards; COUNT1 stays 0. irq stays low because IE=0.
- Wrap and size: WIDTH=32, byte write 0xFF to COUNT2 holding 0x12345600 → reads 0x123456FF. With COUNT2=0xFFFFFFFF, COMPARE2=0, RUN=1 → COUNT2 = 0x00000000 after one tick.
- Collision: W1C of STATUS0 in the same cycle as a match → FLAG0 remains 1. A COUNT0 write of 7 coincident with a tick → reads exactly 7.
- Address decode and mid-run reset: read BASE_ADDR+0xA0 with CHANNELS=4 → data=Z. Read BASE_ADDR+0x28 → 0. Reset pulse while a channel is running → all registers 0 immediately.
